// File: rtl/reg_read_stage.sv
// Register-read stage: selects operands from the register file and holds up to two decoded instructions in a skid FIFO.
// Latency: an instruction pushed into an empty FIFO is at the head one edge later; otherwise it waits behind the older entry.
// Backpressure: in_ready depends only on occupancy (low when FULL), so out_ready never reaches in_ready combinationally.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   q                      register file contents (entry 31 is treated as zero)
//   in_valid/in_ready      decode-side handshake; rn_addr, rm_addr, rd_addr, rd_we carry the instruction
//   wb_en/wb_addr/wb_data  writeback port, used for forwarding when enabled
//   flush                  drops held and incoming instructions
//   out_valid/out_ready    execute-side handshake; out_a, out_b, out_rd, out_we show the head entry
//
// Build option: define REG_READ_BYPASS_EN to forward writebacks into captured and held operands.
module reg_read_stage #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0]    q,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [ADDR_WIDTH-1:0]                       rn_addr,
    input  logic [ADDR_WIDTH-1:0]                       rm_addr,
    input  logic [ADDR_WIDTH-1:0]                       rd_addr,
    input  logic                                        rd_we,
    input  logic                                        wb_en,
    input  logic [ADDR_WIDTH-1:0]                       wb_addr,
    input  logic [DATA_WIDTH-1:0]                       wb_data,
    input  logic                                        flush,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [DATA_WIDTH-1:0]                       out_a,
    output logic [DATA_WIDTH-1:0]                       out_b,
    output logic [ADDR_WIDTH-1:0]                       out_rd,
    output logic                                        out_we
);

    // The highest register number is the hardwired zero register.
    localparam logic [ADDR_WIDTH-1:0] ZERO_REG = '1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [ADDR_WIDTH-1:0] rn;
        logic [ADDR_WIDTH-1:0] rm;
        logic [ADDR_WIDTH-1:0] rd;
        logic                  we;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t head_q, head_d;   // oldest entry, drives the outputs
    entry_t tail_q, tail_d;   // younger entry, valid only when FULL

    logic [DATA_WIDTH-1:0] op_a, op_b;
    entry_t new_ent;
    entry_t head_held, tail_held;
    logic   push, pop;

    assign in_ready = !reset && (state_q != FULL);
    assign push     = in_valid && in_ready && !flush;
    assign pop      = out_valid && out_ready && !flush;

    // Operand select for the incoming instruction.
    always_comb begin
        op_a = (rn_addr == ZERO_REG) ? '0 : q[rn_addr];
        op_b = (rm_addr == ZERO_REG) ? '0 : q[rm_addr];
`ifdef REG_READ_BYPASS_EN
        // The zero-register test on the source also excludes a writeback to it.
        if (wb_en && (rn_addr != ZERO_REG) && (wb_addr == rn_addr)) begin
            op_a = wb_data;
        end
        if (wb_en && (rm_addr != ZERO_REG) && (wb_addr == rm_addr)) begin
            op_b = wb_data;
        end
`endif
        new_ent    = '0;
        new_ent.a  = op_a;
        new_ent.b  = op_b;
        new_ent.rn = rn_addr;
        new_ent.rm = rm_addr;
        new_ent.rd = rd_addr;
        new_ent.we = rd_we;
    end

    // Held entries, refreshed by a matching writeback when forwarding is built in.
    always_comb begin
        head_held = head_q;
        tail_held = tail_q;
`ifdef REG_READ_BYPASS_EN
        if (wb_en && (wb_addr != ZERO_REG)) begin
            if (state_q != EMPTY) begin
                if (head_q.rn == wb_addr) head_held.a = wb_data;
                if (head_q.rm == wb_addr) head_held.b = wb_data;
            end
            if (state_q == FULL) begin
                if (tail_q.rn == wb_addr) tail_held.a = wb_data;
                if (tail_q.rm == wb_addr) tail_held.b = wb_data;
            end
        end
`endif
    end

    // Next-state: flush wins over push/pop; vacated slots are cleared.
    always_comb begin
        state_d = state_q;
        head_d  = head_held;
        tail_d  = tail_held;
        if (flush) begin
            state_d = EMPTY;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (state_q == EMPTY) begin
                        head_d  = new_ent;
                        state_d = ONE;
                    end else begin
                        tail_d  = new_ent;
                        state_d = FULL;
                    end
                end
                2'b01: begin
                    head_d  = tail_held;
                    tail_d  = '0;
                    state_d = (state_q == FULL) ? ONE : EMPTY;
                end
                2'b11: begin
                    // Only reachable from ONE: the single entry leaves and the new one takes the head.
                    head_d  = new_ent;
                    tail_d  = '0;
                    state_d = ONE;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign out_valid = (state_q != EMPTY);
    assign out_a     = out_valid ? head_q.a  : '0;
    assign out_b     = out_valid ? head_q.b  : '0;
    assign out_rd    = out_valid ? head_q.rd : '0;
    assign out_we    = out_valid ? head_q.we : 1'b0;

`ifndef REG_READ_BYPASS_EN
    // Writeback port is only consumed by the forwarding logic.
    logic unused_wb;
    assign unused_wb = ^{wb_en, wb_addr, wb_data};
`endif

endmodule

// File: tb/tb_reg_read_stage.sv
module tb_reg_read_stage;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0][63:0] q;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        rn_addr, rm_addr, rd_addr;
    logic              rd_we;
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [63:0]       wb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_a, out_b;
    logic [4:0]        out_rd;
    logic              out_we;

    always #5 clk = ~clk;

    reg_read_stage dut (
        .clk(clk), .reset(reset), .q(q),
        .in_valid(in_valid), .in_ready(in_ready),
        .rn_addr(rn_addr), .rm_addr(rm_addr), .rd_addr(rd_addr), .rd_we(rd_we),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_we(out_we)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [4:0]  rd;
        logic        we;
    } ent_t;

    ent_t mq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Operand value an instruction should capture, straight from the select rule.
    function automatic logic [63:0] sel(input logic [4:0] s);
        if (s == 5'd31) return 64'd0;
`ifdef REG_READ_BYPASS_EN
        if (wb_en && wb_addr == s) return wb_data;
`endif
        return q[s];
    endfunction

    // Advance the queue model by one edge using the inputs currently applied.
    task automatic model_step();
        ent_t e;
        bit   push, pop;
        if (reset || flush) begin
            mq.delete();
            return;
        end
        push = in_valid && (mq.size() < 2);
        pop  = (mq.size() > 0) && out_ready;
`ifdef REG_READ_BYPASS_EN
        if (wb_en && wb_addr != 5'd31) begin
            foreach (mq[i]) begin
                if (mq[i].rn == wb_addr) mq[i].a = wb_data;
                if (mq[i].rm == wb_addr) mq[i].b = wb_data;
            end
        end
`endif
        if (pop) void'(mq.pop_front());
        if (push) begin
            e.a  = sel(rn_addr);
            e.b  = sel(rm_addr);
            e.rn = rn_addr;
            e.rm = rm_addr;
            e.rd = rd_addr;
            e.we = rd_we;
            mq.push_back(e);
        end
    endtask

    task automatic check_outs(input string tag);
        logic [63:0] ea, eb;
        logic [4:0]  erd;
        logic        ewe;
        ea = 0; eb = 0; erd = 0; ewe = 0;
        if (mq.size() > 0) begin
            ea = mq[0].a; eb = mq[0].b; erd = mq[0].rd; ewe = mq[0].we;
        end
        chk({tag, ".valid"}, {63'd0, out_valid}, {63'd0, mq.size() > 0});
        chk({tag, ".in_ready"}, {63'd0, in_ready}, {63'd0, !reset && mq.size() < 2});
        chk({tag, ".a"}, out_a, ea);
        chk({tag, ".b"}, out_b, eb);
        chk({tag, ".rd"}, {59'd0, out_rd}, {59'd0, erd});
        chk({tag, ".we"}, {63'd0, out_we}, {63'd0, ewe});
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_outs(tag);
    endtask

    task automatic quiet();
        reset = 0; in_valid = 0; flush = 0; wb_en = 0; out_ready = 0;
        rn_addr = 0; rm_addr = 0; rd_addr = 0; rd_we = 0; wb_addr = 0; wb_data = 0;
    endtask

    task automatic push_one(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd, input string tag);
        in_valid = 1; rn_addr = rn; rm_addr = rm; rd_addr = rd; rd_we = 1;
        cycle(tag);
        in_valid = 0;
    endtask

    logic [63:0] exp_v;

    initial begin
        for (int i = 0; i < 32; i++) q[i] = {$urandom, $urandom};
        quiet();
        reset = 1;
        cycle("reset");
        cycle("reset2");
        reset = 0;
        #1;
        check_outs("rst_rel");

        // Single push with a zero-register source, consumed immediately.
        q[3] = 64'h80;
        in_valid = 1; rn_addr = 3; rm_addr = 31; rd_addr = 9; rd_we = 1; out_ready = 1;
        cycle("r19a");
        chk("r19_a", out_a, 64'h80);
        chk("r19_b", out_b, 64'h0);
        in_valid = 0;
        cycle("r19b");
        chk("r19_empty", {63'd0, out_valid}, 64'd0);

        // Stall: three push attempts against a stopped consumer.
        quiet();
        in_valid = 1; rn_addr = 1; rm_addr = 2; rd_we = 1;
        for (int i = 0; i < 3; i++) begin
            rd_addr = 5'(i + 1);
            cycle("r20fill");
            if (i == 1) chk("r20_full_ready", {63'd0, in_ready}, 64'd0);
        end
        in_valid = 0; out_ready = 1;
        cycle("r20d1");
        chk("r20_order", {59'd0, out_rd}, 64'd2);
        cycle("r20d2");
        chk("r20_drained", {63'd0, out_valid}, 64'd0);

        // Writeback on the push cycle.
        quiet();
        q[5] = 64'd1;
        in_valid = 1; rn_addr = 5; rm_addr = 6; rd_addr = 4;
        wb_en = 1; wb_addr = 5; wb_data = 64'hABCD;
`ifdef REG_READ_BYPASS_EN
        exp_v = 64'hABCD;
`else
        exp_v = 64'd1;
`endif
        cycle("r21");
        chk("r21_a", out_a, exp_v);
        quiet(); out_ready = 1;
        cycle("r21d");

        // Writeback into a held entry while FULL; register 31 writeback ignored.
        quiet();
        q[7] = 64'h11;
        push_one(5'd1, 5'd31, 5'd3, "r22p1");
        push_one(5'd4, 5'd7, 5'd6, "r22p2");
        wb_en = 1; wb_addr = 7; wb_data = 64'h55;
        cycle("r22wb");
        wb_addr = 31; wb_data = 64'hFF;
        cycle("r22wb31");
        chk("r22_b31", out_b, 64'd0);
        wb_en = 0; out_ready = 1;
        cycle("r22pop");
`ifdef REG_READ_BYPASS_EN
        exp_v = 64'h55;
`else
        exp_v = 64'h11;
`endif
        chk("r22_b", out_b, exp_v);
        cycle("r22d");

        // Flush while FULL with a live push and pop, then reset mid-stream.
        quiet();
        push_one(5'd8, 5'd9, 5'd10, "r23p1");
        push_one(5'd11, 5'd12, 5'd13, "r23p2");
        flush = 1; in_valid = 1; out_ready = 1;
        cycle("r23fl");
        chk("r23_fl_valid", {63'd0, out_valid}, 64'd0);
        chk("r23_fl_a", out_a, 64'd0);
        quiet();
        push_one(5'd14, 5'd15, 5'd16, "r23p3");
        reset = 1; in_valid = 1; out_ready = 1;
        cycle("r23rst");
        chk("r23_rst_valid", {63'd0, out_valid}, 64'd0);
        quiet();
        #1;
        check_outs("r23rel");

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            q[$urandom_range(31, 0)] = {$urandom, $urandom};
            reset     = ($urandom_range(59, 0) == 0);
            flush     = ($urandom_range(24, 0) == 0);
            in_valid  = $urandom_range(1, 0) == 1;
            out_ready = $urandom_range(2, 0) != 0;
            rn_addr   = 5'($urandom_range(31, 0));
            rm_addr   = ($urandom_range(5, 0) == 0) ? 5'd31 : 5'($urandom_range(31, 0));
            rd_addr   = 5'($urandom_range(31, 0));
            rd_we     = $urandom_range(1, 0) == 1;
            wb_en     = $urandom_range(1, 0) == 1;
            wb_data   = {$urandom, $urandom};
            case ($urandom_range(4, 0))
                0: wb_addr = rn_addr;
                1: wb_addr = rm_addr;
                2: wb_addr = (mq.size() > 0) ? mq[0].rm : 5'd0;
                3: wb_addr = 5'd31;
                default: wb_addr = 5'($urandom_range(31, 0));
            endcase
            cycle("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
